// File: rtl/ifu_fb_pkg.sv
// ---------------------------------------------------------------------------
// ifu_fb_pkg
// Shared types and constants for the IFU fetch buffer.
//   FB_DEPTH_DEF  : default number of fetch-buffer entries
//   FB_DATA_W_MAX : widest fetch-data word an entry can hold; narrower
//                   DATA_W values are zero-padded into the entry
//   fb_entry_t    : one stored fetch (addr[31:1], data, optional parity)
//   fb_parity()   : even-parity bit over {addr, data}
// Optional feature macro: RV_FB_PARITY_EN (adds the per-entry parity bit).
// ---------------------------------------------------------------------------
package ifu_fb_pkg;

  localparam int FB_DEPTH_DEF  = 4;
  localparam int FB_DATA_W_MAX = 128;

  typedef struct packed {
    logic [30:0]              addr;
    logic [FB_DATA_W_MAX-1:0] data;
`ifdef RV_FB_PARITY_EN
    logic                     par;
`endif
  } fb_entry_t;

  // Even parity: the stored bit makes the XOR of {addr, data, par} zero.
  function automatic logic fb_parity(input logic [30:0] addr,
                                     input logic [FB_DATA_W_MAX-1:0] data);
    return ^{addr, data};
  endfunction

endpackage

// File: rtl/ifu_fetch_buf_if.sv
// ---------------------------------------------------------------------------
// ifu_fetch_buf_if
// Bundles the F2 fetch write side and the aligner read/consume side of the
// fetch buffer.
//   master : fetch/aligner side (drives F2 fetch + consume requests)
//   slave  : the fetch buffer (drives entry view + accepted consumes)
// Signals:
//   ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2[30:0], ic_data_f2
//   aln_consume1, aln_consume2
//   fb_valid[1:0], fb_addr0/1[30:0], fb_data0/1, ifu_fb_consume1/2
// ---------------------------------------------------------------------------
interface ifu_fetch_buf_if #(
  parameter int DATA_W = 128
);
  logic              ifc_fetch_req_f2;
  logic              ic_hit_f2;
  logic [30:0]       ifc_fetch_addr_f2;
  logic [DATA_W-1:0] ic_data_f2;
  logic              aln_consume1;
  logic              aln_consume2;
  logic [1:0]        fb_valid;
  logic [30:0]       fb_addr0;
  logic [30:0]       fb_addr1;
  logic [DATA_W-1:0] fb_data0;
  logic [DATA_W-1:0] fb_data1;
  logic              ifu_fb_consume1;
  logic              ifu_fb_consume2;

  modport master (
    output ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_data_f2,
           aln_consume1, aln_consume2,
    input  fb_valid, fb_addr0, fb_addr1, fb_data0, fb_data1,
           ifu_fb_consume1, ifu_fb_consume2
  );

  modport slave (
    input  ifc_fetch_req_f2, ic_hit_f2, ifc_fetch_addr_f2, ic_data_f2,
           aln_consume1, aln_consume2,
    output fb_valid, fb_addr0, fb_addr1, fb_data0, fb_data1,
           ifu_fb_consume1, ifu_fb_consume2
  );
endinterface

// File: rtl/ifu_fb_ptr_ctl.sv
// ---------------------------------------------------------------------------
// ifu_fb_ptr_ctl
// Ring-buffer bookkeeping for the fetch buffer: read/write pointers, entry
// count, consume acceptance and the sticky protocol-error flag.
// Ports:
//   clk, rst                 : clock, asynchronous active-high reset
//   wr_req                   : F2 fetch hit wants to write an entry
//   flush                    : pipeline flush / taken branch (clears ring)
//   consume1, consume2       : aligner consume requests
//   rd_ptr, wr_ptr           : ring pointers
//   count                    : occupied entries
//   wr_acc                   : write accepted this cycle
//   consume1_acc/consume2_acc: consume accepted this cycle
//   err                      : sticky protocol error
// ---------------------------------------------------------------------------
module ifu_fb_ptr_ctl #(
  parameter int FB_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        wr_req,
  input  logic                        flush,
  input  logic                        consume1,
  input  logic                        consume2,
  output logic [$clog2(FB_DEPTH)-1:0] rd_ptr,
  output logic [$clog2(FB_DEPTH)-1:0] wr_ptr,
  output logic [$clog2(FB_DEPTH):0]   count,
  output logic                        wr_acc,
  output logic                        consume1_acc,
  output logic                        consume2_acc,
  output logic                        err
);
  localparam int PW = $clog2(FB_DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [PW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          err_reg, err_next;

  logic [CW-1:0] n_req;
  logic [CW-1:0] n_acc;
  logic          cons_both;
  logic          cons_ok;
  logic          cons_err;
  logic          full;
  logic          drop_err;

  always_comb begin
    n_req = '0;
    if (consume2)
      n_req = CW'(2);
    else if (consume1)
      n_req = CW'(1);

    // Both consume strobes together is a protocol violation: take nothing.
    cons_both = consume1 & consume2;
    cons_ok   = ~flush & ~cons_both & (n_req <= count_reg);
    n_acc     = cons_ok ? n_req : '0;
    cons_err  = ~flush & (cons_both | (n_req > count_reg));

    // A full ring still takes a write if an entry leaves in the same cycle.
    full     = (count_reg == CW'(FB_DEPTH));
    wr_acc   = wr_req & ~flush & (~full | (n_acc != '0));
    drop_err = wr_req & ~flush & full & (n_acc == '0);

    consume1_acc = cons_ok & consume1 & ~consume2;
    consume2_acc = cons_ok & consume2;

    rd_ptr_next = rd_ptr_reg;
    wr_ptr_next = wr_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      rd_ptr_next = '0;
      wr_ptr_next = '0;
      count_next  = '0;
    end else begin
      // Pointer adds truncate to PW bits, giving the modulo-depth wrap.
      rd_ptr_next = rd_ptr_reg + n_acc[PW-1:0];
      wr_ptr_next = wr_ptr_reg + PW'(wr_acc);
      count_next  = count_reg + CW'(wr_acc) - n_acc;
    end
    err_next = err_reg | cons_err | drop_err;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
      err_reg    <= 1'b0;
    end else begin
      rd_ptr_reg <= rd_ptr_next;
      wr_ptr_reg <= wr_ptr_next;
      count_reg  <= count_next;
      err_reg    <= err_next;
    end
  end

  assign rd_ptr = rd_ptr_reg;
  assign wr_ptr = wr_ptr_reg;
  assign count  = count_reg;
  assign err    = err_reg;

endmodule

// File: rtl/ifu_fetch_buf.sv
// ---------------------------------------------------------------------------
// ifu_fetch_buf
// Instruction fetch buffer between F2 fetch and the aligner. F2 hits are
// queued in a FB_DEPTH-entry ring; the two oldest entries are presented to
// the aligner, which consumes one or two per cycle.
// Parameters: FB_DEPTH (power of 2, >= 2), DATA_W (<= FB_DATA_W_MAX)
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : F2 write side, aligner view and consume handshake
//   exu_flush_final : pipeline flush
//   dec_takenbr     : decode taken branch, flushes the buffer
//   fb_count        : occupied entries
//   fb_err          : sticky protocol error (cleared by reset only)
//   fb_perr0        : parity mismatch on oldest valid entry
//                     (only when RV_FB_PARITY_EN is defined)
// Optional feature macro: RV_FB_PARITY_EN.
// ---------------------------------------------------------------------------
module ifu_fetch_buf
  import ifu_fb_pkg::*;
#(
  parameter int FB_DEPTH = FB_DEPTH_DEF,
  parameter int DATA_W   = 128
) (
  input  logic                      clk,
  input  logic                      rst,
  ifu_fetch_buf_if.slave            bus,
  input  logic                      exu_flush_final,
  input  logic                      dec_takenbr,
  output logic [$clog2(FB_DEPTH):0] fb_count,
`ifdef RV_FB_PARITY_EN
  output logic                      fb_perr0,
`endif
  output logic                      fb_err
);
  localparam int PW = $clog2(FB_DEPTH);
  localparam int CW = PW + 1;

  logic          flush;
  logic          wr_req;
  logic          wr_acc;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] rd1_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;

  fb_entry_t entry_mem_reg [FB_DEPTH];
  fb_entry_t wr_entry;
  fb_entry_t rd0_entry;
  fb_entry_t rd1_entry;

  assign flush  = exu_flush_final | dec_takenbr;
  assign wr_req = bus.ifc_fetch_req_f2 & bus.ic_hit_f2;

  ifu_fb_ptr_ctl #(
    .FB_DEPTH (FB_DEPTH)
  ) u_ptr_ctl (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .flush        (flush),
    .consume1     (bus.aln_consume1),
    .consume2     (bus.aln_consume2),
    .rd_ptr       (rd_ptr),
    .wr_ptr       (wr_ptr),
    .count        (count),
    .wr_acc       (wr_acc),
    .consume1_acc (bus.ifu_fb_consume1),
    .consume2_acc (bus.ifu_fb_consume2),
    .err          (fb_err)
  );

  always_comb begin
    wr_entry      = '0;
    wr_entry.addr = bus.ifc_fetch_addr_f2;
    wr_entry.data = FB_DATA_W_MAX'(bus.ic_data_f2);
`ifdef RV_FB_PARITY_EN
    wr_entry.par  = fb_parity(wr_entry.addr, wr_entry.data);
`endif
  end

  // Entry storage is deliberately not reset; validity comes from count.
  always_ff @(posedge clk) begin
    if (wr_acc)
      entry_mem_reg[wr_ptr] <= wr_entry;
  end

  assign rd1_ptr   = rd_ptr + PW'(1);
  assign rd0_entry = entry_mem_reg[rd_ptr];
  assign rd1_entry = entry_mem_reg[rd1_ptr];

  // Valid is masked during the flush cycle so the aligner never sees
  // entries that are about to be discarded.
  assign bus.fb_valid = flush ? 2'b00
                              : {(count >= CW'(2)), (count >= CW'(1))};
  assign bus.fb_addr0 = rd0_entry.addr;
  assign bus.fb_addr1 = rd1_entry.addr;
  assign bus.fb_data0 = rd0_entry.data[DATA_W-1:0];
  assign bus.fb_data1 = rd1_entry.data[DATA_W-1:0];
  assign fb_count     = count;

`ifdef RV_FB_PARITY_EN
  assign fb_perr0 = bus.fb_valid[0] & (^{rd0_entry.addr, rd0_entry.data, rd0_entry.par});
`endif

endmodule

// File: tb/tb_ifu_fetch_buf.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_buf
// Directed bench for ifu_fetch_buf: a vector table for single-cycle
// behaviour plus hand sequences for pointer wrap, asynchronous reset and
// (with RV_FB_PARITY_EN) parity error detection.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_buf;
  import ifu_fb_pkg::*;

  localparam int DW = 128;

  logic       clk = 1'b0;
  logic       rst;
  logic       exu_flush_final;
  logic       dec_takenbr;
  logic [2:0] fb_count;
  logic       fb_err;
`ifdef RV_FB_PARITY_EN
  logic       fb_perr0;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ifu_fetch_buf_if #(.DATA_W(DW)) bus ();

  ifu_fetch_buf #(
    .FB_DEPTH (4),
    .DATA_W   (DW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .exu_flush_final (exu_flush_final),
    .dec_takenbr     (dec_takenbr),
    .fb_count        (fb_count),
`ifdef RV_FB_PARITY_EN
    .fb_perr0        (fb_perr0),
`endif
    .fb_err          (fb_err)
  );

  typedef struct {
    logic        rst_before;
    logic        wr;
    logic [30:0] addr;
    logic        fl_exu;
    logic        fl_br;
    logic        c1;
    logic        c2;
    logic [1:0]  exp_vnow;
    logic        exp_c1;
    logic        exp_c2;
    logic [2:0]  exp_count;
    logic [1:0]  exp_valid;
    logic [30:0] exp_a0;
    logic [30:0] exp_a1;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [DW-1:0] dat(input logic [30:0] a);
    return {4{1'b0, a}};
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok %s = %0h", name, act);
    end
  endtask

  task automatic add(input logic r, input logic w, input logic [30:0] a,
                     input logic fe, input logic fb, input logic c1, input logic c2,
                     input logic [1:0] vn, input logic ec1, input logic ec2,
                     input logic [2:0] cnt, input logic [1:0] val,
                     input logic [30:0] a0, input logic [30:0] a1, input logic er);
    vec_t v;
    v.rst_before = r; v.wr = w; v.addr = a; v.fl_exu = fe; v.fl_br = fb;
    v.c1 = c1; v.c2 = c2; v.exp_vnow = vn; v.exp_c1 = ec1; v.exp_c2 = ec2;
    v.exp_count = cnt; v.exp_valid = val; v.exp_a0 = a0; v.exp_a1 = a1;
    v.exp_err = er;
    vecs.push_back(v);
  endtask

  task automatic idle();
    bus.ifc_fetch_req_f2  = 1'b0;
    bus.ic_hit_f2         = 1'b0;
    bus.ifc_fetch_addr_f2 = '0;
    bus.ic_data_f2        = '0;
    bus.aln_consume1      = 1'b0;
    bus.aln_consume2      = 1'b0;
    exu_flush_final       = 1'b0;
    dec_takenbr           = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset count", DW'(fb_count), '0);
    chk("reset valid", DW'(bus.fb_valid), '0);
    chk("reset err", DW'(fb_err), '0);
    chk("reset cons1", DW'(bus.ifu_fb_consume1), '0);
    chk("reset cons2", DW'(bus.ifu_fb_consume2), '0);
    rst = 1'b0;

    //   rst wr addr   fe fb c1 c2 | vnow  c1 c2 | cnt val    a0     a1   err
    add(0, 1, 31'h100, 0, 0, 0, 0, 2'b00, 0, 0, 3'd1, 2'b01, 31'h100, 31'h0,   0);
    add(0, 1, 31'h108, 0, 0, 0, 0, 2'b01, 0, 0, 3'd2, 2'b11, 31'h100, 31'h108, 0);
    add(0, 1, 31'h110, 0, 0, 0, 0, 2'b11, 0, 0, 3'd3, 2'b11, 31'h100, 31'h108, 0);
    add(0, 1, 31'h118, 0, 0, 0, 0, 2'b11, 0, 0, 3'd4, 2'b11, 31'h100, 31'h108, 0);
    add(0, 1, 31'h120, 0, 0, 0, 1, 2'b11, 0, 1, 3'd3, 2'b11, 31'h110, 31'h118, 0);
    add(0, 0, 31'h0,   0, 0, 1, 0, 2'b11, 1, 0, 3'd2, 2'b11, 31'h118, 31'h120, 0);
    add(0, 1, 31'h128, 0, 0, 0, 0, 2'b11, 0, 0, 3'd3, 2'b11, 31'h118, 31'h120, 0);
    add(0, 1, 31'h130, 0, 0, 0, 0, 2'b11, 0, 0, 3'd4, 2'b11, 31'h118, 31'h120, 0);
    add(0, 1, 31'h138, 0, 0, 0, 0, 2'b11, 0, 0, 3'd4, 2'b11, 31'h118, 31'h120, 1);
    add(0, 0, 31'h0,   0, 0, 0, 1, 2'b11, 0, 1, 3'd2, 2'b11, 31'h128, 31'h130, 1);
    add(0, 1, 31'h140, 1, 0, 1, 0, 2'b00, 0, 0, 3'd0, 2'b00, 31'h0,   31'h0,   1);
    add(1, 1, 31'h200, 0, 0, 0, 0, 2'b00, 0, 0, 3'd1, 2'b01, 31'h200, 31'h0,   0);
    add(0, 0, 31'h0,   0, 0, 0, 1, 2'b01, 0, 0, 3'd1, 2'b01, 31'h200, 31'h0,   1);
    add(0, 0, 31'h0,   0, 0, 1, 0, 2'b01, 1, 0, 3'd0, 2'b00, 31'h0,   31'h0,   1);
    add(0, 1, 31'h300, 0, 1, 0, 0, 2'b00, 0, 0, 3'd0, 2'b00, 31'h0,   31'h0,   1);
    add(1, 1, 31'h300, 0, 0, 0, 0, 2'b00, 0, 0, 3'd1, 2'b01, 31'h300, 31'h0,   0);
    add(0, 0, 31'h0,   0, 0, 1, 1, 2'b01, 0, 0, 3'd1, 2'b01, 31'h300, 31'h0,   1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      if (vecs[i].rst_before) pulse_reset();
      bus.ifc_fetch_req_f2  = vecs[i].wr;
      bus.ic_hit_f2         = vecs[i].wr;
      bus.ifc_fetch_addr_f2 = vecs[i].addr;
      bus.ic_data_f2        = dat(vecs[i].addr);
      exu_flush_final       = vecs[i].fl_exu;
      dec_takenbr           = vecs[i].fl_br;
      bus.aln_consume1      = vecs[i].c1;
      bus.aln_consume2      = vecs[i].c2;
      #2;
      chk($sformatf("v%0d valid_now", i), DW'(bus.fb_valid), DW'(vecs[i].exp_vnow));
      chk($sformatf("v%0d cons1", i), DW'(bus.ifu_fb_consume1), DW'(vecs[i].exp_c1));
      chk($sformatf("v%0d cons2", i), DW'(bus.ifu_fb_consume2), DW'(vecs[i].exp_c2));
      @(posedge clk);
      #1;
      idle();
      #1;
      chk($sformatf("v%0d count", i), DW'(fb_count), DW'(vecs[i].exp_count));
      chk($sformatf("v%0d valid", i), DW'(bus.fb_valid), DW'(vecs[i].exp_valid));
      chk($sformatf("v%0d err", i), DW'(fb_err), DW'(vecs[i].exp_err));
      if (vecs[i].exp_valid[0]) begin
        chk($sformatf("v%0d addr0", i), DW'(bus.fb_addr0), DW'(vecs[i].exp_a0));
        chk($sformatf("v%0d data0", i), bus.fb_data0, dat(vecs[i].exp_a0));
      end
      if (vecs[i].exp_valid[1]) begin
        chk($sformatf("v%0d addr1", i), DW'(bus.fb_addr1), DW'(vecs[i].exp_a1));
        chk($sformatf("v%0d data1", i), bus.fb_data1, dat(vecs[i].exp_a1));
      end
    end

    // Pointer wrap: 6 writes and 6 consumes through a 4-deep ring.
    @(negedge clk);
    pulse_reset();
    bus.ifc_fetch_req_f2  = 1'b1;
    bus.ic_hit_f2         = 1'b1;
    bus.ifc_fetch_addr_f2 = 31'h400;
    bus.ic_data_f2        = dat(31'h400);
    @(posedge clk);
    #1;
    idle();
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i <= 5) begin
        bus.ifc_fetch_req_f2  = 1'b1;
        bus.ic_hit_f2         = 1'b1;
        bus.ifc_fetch_addr_f2 = 31'h400 + 31'(8 * i);
        bus.ic_data_f2        = dat(31'h400 + 31'(8 * i));
      end
      bus.aln_consume1 = 1'b1;
      #2;
      chk($sformatf("wrap%0d addr0", i), DW'(bus.fb_addr0), DW'(31'h400 + 31'(8 * (i - 1))));
      chk($sformatf("wrap%0d data0", i), bus.fb_data0, dat(31'h400 + 31'(8 * (i - 1))));
      chk($sformatf("wrap%0d cons1", i), DW'(bus.ifu_fb_consume1), DW'(1));
      @(posedge clk);
      #1;
      idle();
    end
    #1;
    chk("wrap end count", DW'(fb_count), '0);
    chk("wrap end err", DW'(fb_err), '0);

    // Asynchronous reset between clock edges discards entries at once.
    @(negedge clk);
    bus.ifc_fetch_req_f2  = 1'b1;
    bus.ic_hit_f2         = 1'b1;
    bus.ifc_fetch_addr_f2 = 31'h500;
    bus.ic_data_f2        = dat(31'h500);
    repeat (2) @(posedge clk);
    #1;
    idle();
    chk("pre-areset count", DW'(fb_count), DW'(2));
    #1;
    rst = 1'b1;
    #1;
    chk("areset count", DW'(fb_count), '0);
    chk("areset valid", DW'(bus.fb_valid), '0);
    rst = 1'b0;

`ifdef RV_FB_PARITY_EN
    @(negedge clk);
    pulse_reset();
    bus.ifc_fetch_req_f2  = 1'b1;
    bus.ic_hit_f2         = 1'b1;
    bus.ifc_fetch_addr_f2 = 31'h600;
    bus.ic_data_f2        = dat(31'h600);
    @(posedge clk);
    #1;
    idle();
    #1;
    chk("perr clean", DW'(fb_perr0), '0);
    dut.entry_mem_reg[0].data[0] = ~dut.entry_mem_reg[0].data[0];
    #1;
    chk("perr flipped", DW'(fb_perr0), DW'(1));
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch_buf.md
IFU_FETCH_BUF -- requirements
Module: ifu_fetch_buf

Interface
REQ-001 SHALL have parameter FB_DEPTH, default 4, number of fetch-buffer entries (power of 2, min 2).
REQ-002 SHALL have parameter DATA_W, default 128, bits of fetch data per entry.
REQ-003 SHALL have port clk  input  1  single clock, all flops rising-edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port ifc_fetch_req_f2  input  1  F2 fetch valid.
REQ-006 SHALL have port ic_hit_f2  input  1  F2 data valid (cache/ICCM hit).
REQ-007 SHALL have port ifc_fetch_addr_f2  input  31  F2 fetch address [31:1].
REQ-008 SHALL have port ic_data_f2  input  DATA_W  F2 fetch data.
REQ-009 SHALL have port exu_flush_final  input  1  pipeline flush.
REQ-010 SHALL have port dec_takenbr  input  1  decode static taken branch, flushes buffer.
REQ-011 SHALL have port aln_consume1 / aln_consume2  input  1 each  aligner consumed 1 / 2 entries (mutually exclusive).
REQ-012 SHALL have port fb_valid  output  2  valid of the two oldest entries (bit0 = oldest).
REQ-013 SHALL have port fb_addr0 / fb_addr1  output  31 each  addresses of oldest / next entry.
REQ-014 SHALL have port fb_data0 / fb_data1  output  DATA_W each  data of oldest / next entry.
REQ-015 SHALL have port ifu_fb_consume1 / ifu_fb_consume2  output  1 each  accepted consumes, to fetch control.
REQ-016 SHALL have port fb_count  output  $clog2(FB_DEPTH)+1  occupied entries.
REQ-017 SHALL have port fb_err  output  1  sticky protocol-error flag.

Function
REQ-018 SHALL write one entry when wr = ifc_fetch_req_f2 & ic_hit_f2 & ~flush, where flush = exu_flush_final | dec_takenbr.
REQ-019 SHALL organise storage as a ring: rd_ptr, wr_ptr (log2 FB_DEPTH bits, wrap modulo FB_DEPTH), count register.
REQ-020 SHALL accept consume n (n=1 or 2) only if n <= count; accepted consume drives ifu_fb_consume1/2 combinationally same cycle.
REQ-021 SHALL, for consume n > count, accept nothing, drive ifu_fb_consume1/2 low, set fb_err.
REQ-022 SHALL next-state count = count + wr_acc - n_acc; write with simultaneous consume on full buffer accepted when n_acc >= 1.
REQ-023 SHALL drop write when count == FB_DEPTH and n_acc == 0, and set fb_err.
REQ-024 SHALL on flush clear count, rd_ptr, wr_ptr next cycle; same-cycle writes and consumes ignored; fb_valid forced 0 combinationally during flush cycle.
REQ-025 SHALL present fb_valid[0] = count>=1, fb_valid[1] = count>=2; data/addr of invalid slots don't-care.
REQ-026 SHALL make written entry visible on fb_* one cycle after write (no F2 bypass).
REQ-027 SHALL clear fb_err only by reset.

Reset
REQ-028 SHALL reset count, pointers, fb_valid, ifu_fb_consume1/2, fb_err to 0; entry storage not reset.
REQ-029 SHALL on reset assertion mid-operation discard all entries immediately (asynchronous).

Configuration
REQ-030 SHALL with RV_FB_PARITY_EN defined store one even-parity bit over {addr,data} per entry and add output fb_perr0 (1) = parity mismatch on oldest valid entry, combinational.
REQ-031 SHALL without RV_FB_PARITY_EN omit parity storage and port fb_perr0.

Structure
REQ-032 SHALL place entry struct typedef (addr, data, optional parity) and FB_DEPTH default constant in shared package ifu_fb_pkg.
REQ-033 SHALL implement pointer/count bookkeeping in sub-module ifu_fb_ptr_ctl; storage and muxing in top.

Verification
REQ-034 SHALL test: reset, then 3 hits at 0x100,0x108,0x110 (addr[31:1]) -> fb_count=3, fb_addr0=0x100, fb_addr1=0x108.
REQ-035 SHALL test: count=4, wr + consume2 same cycle -> count=3, consume2 output high, fb_err=0.
REQ-036 SHALL test: count=4, wr without consume -> write dropped, count=4, fb_err=1.
REQ-037 SHALL test: count=2, flush + wr + consume1 same cycle -> fb_valid=0 that cycle, consume1 output low, count=0 next.
REQ-038 SHALL test: count=1, consume2 -> ifu_fb_consume2=0, count stays 1, fb_err=1.
REQ-039 SHALL test: RV_FB_PARITY_EN, force bit flip in oldest entry -> fb_perr0=1; 6 writes/6 consumes -> pointers wrap, data order preserved.
